// File: rtl/iir_decimator.sv
// ============================================================================
// Module      : iir_decimator
// Description : Keeps every DECIM-th valid sample from the IIR filter output.
//               Each kept sample is scaled by an arithmetic right shift and
//               saturated to out_bits. Kept samples are queued in a small
//               FIFO that drives a valid/ready interface. A sticky overflow
//               flag records any kept sample lost because the FIFO was full.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module iir_decimator #(
    parameter int no_bits    = 32,
    parameter int out_bits   = 16,
    parameter int DECIM      = 4,
    parameter int SHIFT      = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic signed [no_bits-1:0]     in,
    input  logic                          in_valid,
    output logic signed [out_bits-1:0]    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    // A 1-bit counter is kept even when DECIM=1 so the compare stays legal.
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] LAST_PHASE = CW'(DECIM - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    // Saturation limits expressed at the input width so the compare is exact.
    localparam logic signed [no_bits-1:0] SAT_MAX =
        {{(no_bits - out_bits + 1){1'b0}}, {(out_bits - 1){1'b1}}};
    localparam logic signed [no_bits-1:0] SAT_MIN =
        {{(no_bits - out_bits + 1){1'b1}}, {(out_bits - 1){1'b0}}};

    logic [CW-1:0]                 phase;
    logic [AW-1:0]                 wr_ptr;
    logic [AW-1:0]                 rd_ptr;
    logic [AW:0]                   level;
    logic                          ovf;
    logic signed [out_bits-1:0]    mem [FIFO_DEPTH];

    logic                          keep;
    logic                          full;
    logic                          pop;
    logic                          push;
    logic                          drop;
    logic signed [no_bits-1:0]     scaled;
    logic signed [out_bits-1:0]    sat_val;

    // Decimation decision, handshake qualifiers and scale/saturate path.
    always_comb begin
        keep    = in_valid && (phase == LAST_PHASE);
        full    = (level == FULL_LEVEL);
        pop     = (level != '0) && out_ready;
        push    = keep && (!full || pop);
        drop    = keep && full && !pop;
        scaled  = in >>> SHIFT;
        sat_val = scaled[out_bits-1:0];
        if (scaled > SAT_MAX) begin
            sat_val = SAT_MAX[out_bits-1:0];
        end else if (scaled < SAT_MIN) begin
            sat_val = SAT_MIN[out_bits-1:0];
        end
    end

    // Phase counter advances only on valid input samples and wraps on keep.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= keep ? '0 : phase + CW'(1);
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave level alone.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written after reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= sat_val;
        end
    end

    // Sticky overflow; a fresh drop takes priority over a clear request.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    // Outputs come from state only; empty FIFO presents zero data.
    always_comb begin
        out_valid  = (level != '0);
        out_data   = out_valid ? mem[rd_ptr] : '0;
        fifo_level = level;
        overflow   = ovf;
    end

endmodule

`default_nettype wire

// File: tb/tb_iir_decimator.sv
// ============================================================================
// Module      : tb_iir_decimator
// Description : Scoreboard bench for iir_decimator. Stimulus pushes expected
//               output samples; per-instance monitors pop and compare on
//               every accepted output beat.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iir_decimator;

    logic CLK = 1'b0;
    logic reset;

    // Default instance: DECIM=4, SHIFT=0
    logic signed [31:0] in0;
    logic               in_valid0, out_ready0, clr_ovf0;
    logic signed [15:0] out_data0;
    logic               out_valid0, overflow0;
    logic [2:0]         fifo_level0;

    // DECIM=1, SHIFT=0
    logic signed [31:0] in1;
    logic               in_valid1, out_ready1;
    logic signed [15:0] out_data1;
    logic               out_valid1, overflow1;
    logic [2:0]         fifo_level1;

    // DECIM=1, SHIFT=4
    logic signed [31:0] in2;
    logic               in_valid2, out_ready2;
    logic signed [15:0] out_data2;
    logic               out_valid2, overflow2;
    logic [2:0]         fifo_level2;

    logic signed [15:0] q0[$];
    logic signed [15:0] q1[$];
    logic signed [15:0] q2[$];

    int checks = 0;
    int errors = 0;

    iir_decimator dut0 (
        .CLK(CLK), .reset(reset), .in(in0), .in_valid(in_valid0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .fifo_level(fifo_level0), .overflow(overflow0), .clr_ovf(clr_ovf0)
    );

    iir_decimator #(.DECIM(1), .SHIFT(0)) dut1 (
        .CLK(CLK), .reset(reset), .in(in1), .in_valid(in_valid1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .fifo_level(fifo_level1), .overflow(overflow1), .clr_ovf(1'b0)
    );

    iir_decimator #(.DECIM(1), .SHIFT(4)) dut2 (
        .CLK(CLK), .reset(reset), .in(in2), .in_valid(in_valid2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .fifo_level(fifo_level2), .overflow(overflow2), .clr_ovf(1'b0)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitors sample at the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected: got %0d, expected no output", out_data0);
            end else begin
                check("dut0_data", out_data0, q0.pop_front());
            end
        end
        if (out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected: got %0d, expected no output", out_data1);
            end else begin
                check("dut1_data", out_data1, q1.pop_front());
            end
        end
        if (out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2_unexpected: got %0d, expected no output", out_data2);
            end else begin
                check("dut2_data", out_data2, q2.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one cycle on the default instance; optionally record an expectation.
    task automatic drive0(input int v, input logic vld, input logic exp_keep);
        in0       = v;
        in_valid0 = vld;
        if (exp_keep) q0.push_back(16'(v));
        tick();
        in_valid0 = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        check({name, "_drained"}, q0.size() + q1.size() + q2.size(), 0);
    endtask

    initial begin
        reset = 1'b0;
        in0 = 0; in_valid0 = 0; out_ready0 = 0; clr_ovf0 = 0;
        in1 = 0; in_valid1 = 0; out_ready1 = 0;
        in2 = 0; in_valid2 = 0; out_ready2 = 0;
        tick();
        tick();
        check("rst_level", fifo_level0, 0);
        check("rst_valid", out_valid0, 0);
        check("rst_data", out_data0, 0);
        check("rst_ovf", overflow0, 0);
        reset = 1'b1;

        // Test 1: every fourth sample kept with one-cycle latency.
        out_ready0 = 1'b1;
        for (int i = 1; i <= 3; i++) drive0(i, 1'b1, 1'b0);
        check("t1_not_yet", out_valid0, 0);
        drive0(4, 1'b1, 1'b1);
        check("t1_valid4", out_valid0, 1);
        check("t1_data4", out_data0, 4);
        for (int i = 5; i <= 8; i++) drive0(i, 1'b1, i == 8);
        for (int i = 0; i < 3; i++) tick();
        wait_drain("t1");
        check("t1_level", fifo_level0, 0);
        check("t1_ovf", overflow0, 0);

        // Test 2: saturation and arithmetic shift on DECIM=1 instances.
        out_ready1 = 1'b1;
        out_ready2 = 1'b1;
        in_valid1 = 1'b1;
        in1 = 40000;  q1.push_back(16'sd32767);  tick();
        in1 = -40000; q1.push_back(-16'sd32768); tick();
        in1 = -5;     q1.push_back(-16'sd5);     tick();
        in1 = 32767;  q1.push_back(16'sd32767);  tick();
        in1 = -32768; q1.push_back(-16'sd32768); tick();
        in_valid1 = 1'b0;
        in_valid2 = 1'b1;
        in2 = -40000; q2.push_back(-16'sd2500);  tick();
        in2 = 600000; q2.push_back(16'sd32767);  tick();
        in_valid2 = 1'b0;
        wait_drain("t2");

        // Test 3: overflow on a stalled consumer, drain, then clear.
        out_ready0 = 1'b0;
        for (int i = 1; i <= 20; i++) drive0(i, 1'b1, (i % 4 == 0) && (i < 20));
        check("t3_level_full", fifo_level0, 4);
        check("t3_ovf_set", overflow0, 1);
        out_ready0 = 1'b1;
        wait_drain("t3");
        check("t3_level_empty", fifo_level0, 0);
        check("t3_ovf_sticky", overflow0, 1);
        clr_ovf0 = 1'b1;
        tick();
        clr_ovf0 = 1'b0;
        check("t3_ovf_clr", overflow0, 0);

        // Test 4: phase counter ignores idle cycles.
        drive0(10, 1'b1, 1'b0);
        drive0(99, 1'b0, 1'b0);
        drive0(99, 1'b0, 1'b0);
        drive0(20, 1'b1, 1'b0);
        drive0(30, 1'b1, 1'b0);
        drive0(99, 1'b0, 1'b0);
        drive0(40, 1'b1, 1'b1);
        tick();
        wait_drain("t4");

        // Test 5: full FIFO with simultaneous pop accepts the new sample.
        out_ready0 = 1'b0;
        for (int i = 1; i <= 19; i++) drive0(i, 1'b1, i % 4 == 0);
        check("t5_level_full", fifo_level0, 4);
        out_ready0 = 1'b1;
        drive0(20, 1'b1, 1'b1);
        check("t5_level_same", fifo_level0, 4);
        check("t5_no_ovf", overflow0, 0);
        wait_drain("t5");

        // Test 6: reset mid-stream discards FIFO and phase.
        out_ready0 = 1'b0;
        for (int i = 1; i <= 10; i++) drive0(i, 1'b1, 1'b0);
        check("t6_level_pre", fifo_level0, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t6_level", fifo_level0, 0);
        check("t6_valid", out_valid0, 0);
        check("t6_data", out_data0, 0);
        check("t6_ovf", overflow0, 0);
        out_ready0 = 1'b1;
        for (int i = 1; i <= 3; i++) drive0(i * 100, 1'b1, 1'b0);
        check("t6_phase", fifo_level0, 0);
        drive0(400, 1'b1, 1'b1);
        check("t6_kept", out_data0, 400);
        wait_drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
